// File: rtl/fpu_convert_pipe.sv
// Pipelined int<->single-precision float converter with valid/ready handshake,
// RISC-V rounding modes and NV/NX exception flags.
module fpu_convert_pipe #(
  parameter int unsigned STAGES  = 2,
  parameter logic [4:0]  OP_S_W  = 5'b11001,
  parameter logic [4:0]  OP_S_WU = 5'b11010,
  parameter logic [4:0]  OP_W_S  = 5'b10110,
  parameter logic [4:0]  OP_WU_S = 5'b10111
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [4:0]  i_alu_op,
  input  logic [2:0]  i_rm,
  input  logic [31:0] i_operand_a,
  input  logic [31:0] i_rs1_f,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_data_convert,
  output logic [4:0]  o_fflags
);

  typedef enum logic [1:0] {K_CONST, K_I2F, K_F2I} kind_t;

  // Decoded operation carried between the front (decode/LZC/shift) and back (round/pack) halves
  typedef struct packed {
    kind_t       kind;
    logic        sign;
    logic [2:0]  rm;
    logic        wu;
    logic        big;
    logic [32:0] mag;
    logic        guard;
    logic        sticky;
    logic [7:0]  exp;
    logic [31:0] res;
    logic [4:0]  flags;
  } mid_t;

  function automatic logic [5:0] lzc32(input logic [31:0] x);
    logic [5:0] n;
    logic       found;
    n     = 6'd32;
    found = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (!found && x[31-i]) begin
        n     = 6'(i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic logic round_up(input logic [2:0] rm, input logic sign,
                                    input logic lsb, input logic g, input logic s);
    case (rm)
      3'b001:  return 1'b0;
      3'b010:  return sign & (g | s);
      3'b011:  return !sign & (g | s);
      3'b100:  return g;
      default: return g & (s | lsb);
    endcase
  endfunction

  mid_t        front;
  mid_t        mid;
  logic        mid_valid;
  logic        out_en;
  logic [31:0] back_res;
  logic [4:0]  back_flags;

  logic [31:0] mag_i;
  logic [5:0]  lz;
  logic [31:0] norm;
  logic [7:0]  e_f;
  logic [7:0]  e_eff;
  logic [7:0]  sh;
  logic [23:0] sig;
  logic [49:0] ext;

  always_comb begin
    front    = '0;
    front.rm = (i_rm > 3'd4) ? 3'd0 : i_rm;
    mag_i    = '0;
    lz       = '0;
    norm     = '0;
    e_f      = '0;
    e_eff    = '0;
    sh       = '0;
    sig      = '0;
    ext      = '0;
    if (i_alu_op == OP_S_W || i_alu_op == OP_S_WU) begin
      front.sign = (i_alu_op == OP_S_W) && i_operand_a[31];
      mag_i      = front.sign ? -i_operand_a : i_operand_a;
      lz         = lzc32(mag_i);
      norm       = mag_i << lz;
      if (mag_i == '0) begin
        front.kind = K_CONST;
        front.sign = 1'b0;
      end else begin
        front.kind   = K_I2F;
        front.mag    = {9'd0, norm[31:8]};
        front.guard  = norm[7];
        front.sticky = |norm[6:0];
        front.exp    = 8'd158 - {2'b00, lz};
      end
    end else if (i_alu_op == OP_W_S || i_alu_op == OP_WU_S) begin
      front.wu   = (i_alu_op == OP_WU_S);
      front.sign = i_rs1_f[31];
      e_f        = i_rs1_f[30:23];
      if (e_f == 8'hFF) begin
        // NaN saturates like +inf; only -inf takes the negative limit
        front.kind  = K_CONST;
        front.flags = 5'b10000;
        if (i_rs1_f[22:0] != '0 || !front.sign)
          front.res = front.wu ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
        else
          front.res = front.wu ? 32'h0000_0000 : 32'h8000_0000;
      end else begin
        front.kind = K_F2I;
        sig        = {(e_f != 8'd0), i_rs1_f[22:0]};
        e_eff      = (e_f == 8'd0) ? 8'd1 : e_f;
        if (e_eff >= 8'd159) begin
          front.big = 1'b1;
        end else if (e_eff >= 8'd150) begin
          sh        = e_eff - 8'd150;
          front.mag = {9'd0, sig} << sh;
        end else begin
          // Beyond 26 places every significand bit is sticky, so clamp the shift
          sh           = 8'd150 - e_eff;
          if (sh > 8'd26) sh = 8'd26;
          ext          = {sig, 26'd0} >> sh;
          front.mag    = {9'd0, ext[49:26]};
          front.guard  = ext[25];
          front.sticky = |ext[24:0];
        end
      end
    end else begin
      front.kind = K_CONST;
    end
  end

  logic        up;
  logic [24:0] sum24;
  logic [32:0] mag_r;
  logic        inexact;

  always_comb begin
    back_res   = mid.res;
    back_flags = mid.flags;
    inexact    = mid.guard | mid.sticky;
    up         = round_up(mid.rm, mid.sign, mid.mag[0], mid.guard, mid.sticky);
    sum24      = {1'b0, mid.mag[23:0]} + 25'(up);
    mag_r      = mid.mag + 33'(up);
    case (mid.kind)
      K_I2F: begin
        back_res   = {mid.sign, mid.exp + 8'(sum24[24]), sum24[22:0]};
        back_flags = {4'b0000, inexact};
      end
      K_F2I: begin
        if (mid.wu) begin
          if (mid.sign) begin
            back_res   = '0;
            back_flags = (mid.big || mag_r != '0) ? 5'b10000 : {4'b0000, inexact};
          end else if (mid.big || mag_r[32]) begin
            back_res   = 32'hFFFF_FFFF;
            back_flags = 5'b10000;
          end else begin
            back_res   = mag_r[31:0];
            back_flags = {4'b0000, inexact};
          end
        end else if (mid.sign) begin
          if (mid.big || mag_r > 33'h0_8000_0000) begin
            back_res   = 32'h8000_0000;
            back_flags = 5'b10000;
          end else begin
            back_res   = -mag_r[31:0];
            back_flags = {4'b0000, inexact};
          end
        end else if (mid.big || mag_r > 33'h0_7FFF_FFFF) begin
          back_res   = 32'h7FFF_FFFF;
          back_flags = 5'b10000;
        end else begin
          back_res   = mag_r[31:0];
          back_flags = {4'b0000, inexact};
        end
      end
      default: begin
        back_res   = mid.res;
        back_flags = mid.flags;
      end
    endcase
  end

  assign out_en = !o_valid || i_ready;

  generate
    if (STAGES == 2) begin : g_two
      mid_t s1_q;
      logic s1_valid;
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          s1_valid <= 1'b0;
          s1_q     <= '0;
        end else if (o_ready) begin
          s1_valid <= i_valid;
          if (i_valid) s1_q <= front;
        end
      end
      assign o_ready   = !s1_valid || out_en;
      assign mid       = s1_q;
      assign mid_valid = s1_valid;
    end else begin : g_one
      assign o_ready   = out_en;
      assign mid       = front;
      assign mid_valid = i_valid;
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid        <= 1'b0;
      o_data_convert <= '0;
      o_fflags       <= '0;
    end else if (out_en) begin
      o_valid <= mid_valid;
      if (mid_valid) begin
        o_data_convert <= back_res;
        o_fflags       <= back_flags;
      end
    end
  end

endmodule
